// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux channel multiplexer.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DWELL   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Successor of a channel index in a ring of n channels.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/scan_mux_rr_next_ch.sv
// rr_next_ch: finds the first enabled channel at or after ptr, wrapping N_CH-1 -> 0.
module rr_next_ch #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_CH-1:0]  ch_mask,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [2*N_CH-1:0] rot;
    int                off;
    int                sum;

    // Rotating a doubled mask puts the channel at offset i from ptr at bit i.
    always_comb begin
        rot   = {ch_mask, ch_mask} >> ptr;
        off   = 0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= N_CH) begin
            sum = sum - N_CH;
        end
        idx = SEL_W'(sum);
    end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: manual or round-robin channel multiplexer with valid/ready output and scan dwell.
// Optional registered even-parity output enabled by defining SCAN_MUX_PARITY_EN.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int DATA_W  = 8,
    parameter  int DWELL_W = 8,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] i_data,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   mode,
    input  logic [N_CH-1:0]        ch_mask,
    input  logic [DWELL_W-1:0]     dwell,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch
`ifdef SCAN_MUX_PARITY_EN
    ,
    output logic                   out_parity
`endif
);

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [DWELL_W-1:0] cnt;

    logic [SEL_W-1:0]   ptr_next;
    logic [SEL_W-1:0]   search_ptr;
    logic [SEL_W-1:0]   rr_idx;
    logic               rr_found;
    logic [SEL_W-1:0]   load_idx;
    logic [DATA_W-1:0]  load_word;
    logic               load_en;

    // During a scan transfer the search already starts from the advanced pointer.
    always_comb begin
        ptr_next   = SEL_W'(wrap_inc(int'(out_ch), N_CH));
        search_ptr = (state == PRESENT) ? ptr_next : ptr;
    end

    rr_next_ch #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_next_ch (
        .ptr     (search_ptr),
        .ch_mask (ch_mask),
        .idx     (rr_idx),
        .found   (rr_found)
    );

    // Out-of-range manual selects fall through the loop and load zero.
    always_comb begin
        load_idx  = (mode == MODE_MANUAL) ? sel : rr_idx;
        load_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (load_idx == SEL_W'(k)) begin
                load_word = i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        load_en = 1'b0;
        case (state)
            IDLE:    load_en = (mode == MODE_MANUAL) || rr_found;
            PRESENT: load_en = out_ready &&
                               ((mode == MODE_MANUAL) || ((dwell == '0) && rr_found));
            default: load_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            if (load_en) begin
                out_data <= load_word;
                out_ch   <= load_idx;
            end
            case (state)
                IDLE: begin
                    if (load_en) begin
                        state     <= PRESENT;
                        out_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready && (mode == MODE_SCAN)) begin
                        ptr <= ptr_next;
                        if (dwell != '0) begin
                            cnt       <= dwell;
                            state     <= DWELL;
                            out_valid <= 1'b0;
                        end else if (!rr_found) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                DWELL: begin
                    cnt <= cnt - DWELL_W'(1);
                    if (cnt <= DWELL_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_MUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else if (load_en) begin
            out_parity <= ^load_word;
        end
    end
`endif

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: transaction-level channel-order model, monitor checks
// transfers, hold stability and inter-transfer gaps (parity when SCAN_MUX_PARITY_EN).
module tb_scan_mux;
    import scan_mux_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_data = '0;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0;
    logic [3:0]  ch_mask = 4'hF;
    logic [7:0]  dwell = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
`ifdef SCAN_MUX_PARITY_EN
    logic        out_parity;
`endif

    scan_mux #(.N_CH(4), .DATA_W(8), .DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .sel       (sel),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch)
`ifdef SCAN_MUX_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } word_t;

    word_t sb_q[$];
    word_t held;
    int    m_ptr = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    ready_pct = 100;
    bit    hold_ready = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Word the DUT should load next, from the current configuration and scan pointer.
    function automatic word_t pick();
        word_t w;
        int    c;
        bit    hit;
        c   = 0;
        hit = 1'b0;
        if (mode == MODE_MANUAL) begin
            c = int'(sel);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!hit && ch_mask[(m_ptr + i) % 4]) begin
                    hit = 1'b1;
                    c   = (m_ptr + i) % 4;
                end
            end
        end
        w.ch   = 2'(c);
        w.data = i_data[c*8 +: 8];
        return w;
    endfunction

    // A scan-mode transfer moves the pointer past the transferred channel.
    function automatic void xfer(input logic [1:0] ch);
        if (mode == MODE_SCAN) m_ptr = (int'(ch) + 1) % 4;
    endfunction

    task automatic gen_phase(input int k, input bit have_held);
        word_t w;
        if (have_held) begin
            sb_q.push_back(held);
            xfer(held.ch);
        end
        repeat (k) begin
            w = pick();
            sb_q.push_back(w);
            xfer(w.ch);
        end
        held = pick();
    endtask

    task automatic set_cfg(input logic m, input logic [1:0] s, input logic [3:0] msk,
                           input logic [7:0] dw, input logic [31:0] d);
        mode    = m;
        sel     = s;
        ch_mask = msk;
        dwell   = dw;
        i_data  = d;
    endtask

    task automatic do_reset_cfg(input logic m, input logic [1:0] s, input logic [3:0] msk,
                                input logic [7:0] dw, input logic [31:0] d);
        @(posedge clk); #1;
        rst = 1'b1;
        set_cfg(m, s, msk, dw, d);
        m_ptr = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
`ifdef SCAN_MUX_PARITY_EN
        chk("rst_parity", out_parity, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() > 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d words never transferred", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("held_word_timeout", out_valid, 1);
    endtask

    task automatic run_phase(input bit do_reset, input int k, input logic m, input logic [1:0] s,
                             input logic [3:0] msk, input logic [7:0] dw, input int pct,
                             input logic [31:0] d);
        ready_pct = pct;
        if (do_reset) begin
            do_reset_cfg(m, s, msk, dw, d);
            gen_phase(k, 1'b0);
            @(negedge clk);
            chk("idle_after_rst", out_valid, 0);
            @(negedge clk);
            chk("load_latency", out_valid, 1);
        end else begin
            wait_valid();
            @(posedge clk); #1;
            set_cfg(m, s, msk, dw, d);
            gen_phase(k, 1'b1);
        end
        drain();
    endtask

    // Ready driver: only offers ready while the scoreboard expects more words.
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = !hold_ready && (sb_q.size() > 0) && (int'($urandom_range(99)) < ready_pct);
        end
    end

    // Monitor: compares transfers, hold stability and gaps between transfers.
    initial begin
        bit    prev_hold;
        word_t prev_w;
        word_t w;
        bit    gap_pend;
        int    gap_cnt;
        int    gap_exp;
        prev_hold = 1'b0;
        gap_pend  = 1'b0;
        gap_cnt   = 0;
        gap_exp   = 0;
        prev_w    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                gap_pend  = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_word", {out_ch, out_data}, prev_w);
                end
                if (gap_pend) begin
                    if (!out_valid) begin
                        gap_cnt++;
                    end else begin
                        chk("gap_cycles", gap_cnt, gap_exp);
                        gap_pend = 1'b0;
                    end
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_xfer: ch %0d data 0x%0h, none expected", out_ch, out_data);
                    end else begin
                        w = sb_q.pop_front();
                        chk("xfer_ch", out_ch, w.ch);
                        chk("xfer_data", out_data, w.data);
`ifdef SCAN_MUX_PARITY_EN
                        chk("xfer_parity", out_parity, ^w.data);
`endif
                    end
                    gap_pend = 1'b1;
                    gap_cnt  = 0;
                    gap_exp  = (mode == MODE_SCAN && dwell != 0) ? int'(dwell) + 1 : 0;
                end
                prev_hold = out_valid && !out_ready;
                prev_w    = {out_ch, out_data};
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          rs;
        // Manual back-to-back on channel 2.
        run_phase(1'b1, 8, MODE_MANUAL, 2'd2, 4'hF, 8'd0, 100, 32'hDDCC_BBAA);

        // Backpressure while channel 1 data changes underneath the held word.
        hold_ready = 1'b1;
        do_reset_cfg(MODE_MANUAL, 2'd1, 4'hF, 8'd0, 32'hDDCC_BBAA);
        sb_q.push_back('{ch: 2'd1, data: 8'hBB});
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        i_data[15:8] = 8'h11;
        sb_q.push_back('{ch: 2'd1, data: 8'h11});
        repeat (3) @(posedge clk);
        #1;
        hold_ready = 1'b0;
        ready_pct  = 100;
        drain();

        // Scan over a sparse mask with no dwell, then full mask with dwell.
        run_phase(1'b1, 8, MODE_SCAN, 2'd0, 4'b1010, 8'd0, 100, $urandom);
        run_phase(1'b1, 5, MODE_SCAN, 2'd0, 4'b1111, 8'd3, 100, $urandom);

        // Emptying the mask lets the held word go, then nothing more is presented.
        wait_valid();
        @(posedge clk); #1;
        ch_mask = 4'b0000;
        sb_q.push_back(held);
        drain();
        repeat (12) begin
            @(negedge clk);
            chk("empty_mask_idle", out_valid, 0);
        end

        // Parity-friendly data, then a sel change while a word is held.
        run_phase(1'b1, 4, MODE_MANUAL, 2'd0, 4'hF, 8'd0, 100, 32'h0000_0307);
        run_phase(1'b0, 4, MODE_MANUAL, 2'd1, 4'hF, 8'd0, 70, 32'h0000_0307);

        for (int r = 0; r < 12; r++) begin
            rs = (r == 0) || ($urandom_range(2) == 0);
            rd = $urandom;
            run_phase(rs, int'($urandom_range(12, 4)), 1'($urandom_range(1)),
                      2'($urandom_range(3)), 4'($urandom_range(15, 1)),
                      8'($urandom_range(4)), int'($urandom_range(100, 30)), rd);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
- REQ-001 Parameter N_CH, default 4, number of input channels (2..16).
- REQ-002 Parameter DATA_W, default 8, width of each channel's data.
- REQ-003 Parameter DWELL_W, default 8, width of the dwell counter.
- REQ-004 clk  in  1  single clock; all state changes on rising edge.
- REQ-005 rst  in  1  synchronous, active-high reset.
- REQ-006 i_data  in  N_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- REQ-007 sel  in  SEL_W=$clog2(N_CH)  manual channel select.
- REQ-008 mode  in  1  0 = manual, 1 = auto-scan.
- REQ-009 ch_mask  in  N_CH  channels eligible for scan; bit k enables channel k.
- REQ-010 dwell  in  DWELL_W  idle cycles inserted after each scan transfer.
- REQ-011 out_ready  in  1  downstream accepts the presented word.
- REQ-012 out_valid  out  1  out_data/out_ch are valid.
- REQ-013 out_data  out  DATA_W  registered selected data.
- REQ-014 out_ch  out  SEL_W  channel index of out_data.

Function
- REQ-015 The FSM SHALL have three states: IDLE, PRESENT and DWELL.
- REQ-016 Out_valid SHALL be 1 exactly in PRESENT.
- REQ-017 Handshake: a transfer occurs on an edge where out_valid && out_ready.
  - out_data/out_ch SHALL stay stable while out_valid && !out_ready.
- REQ-018 Load: i_data of the chosen channel is sampled into out_data at the load edge, and out_ch takes that index.
  - Latency from load to out_valid is 1 cycle.
- REQ-019 IDLE, manual mode: load channel sel, then go to PRESENT.
- REQ-020 IDLE, scan mode, ch_mask != 0: load the first enabled channel at or after scan pointer ptr (with wrap), then go to PRESENT.
  - ch_mask == 0: remain in IDLE with out_valid = 0.
- REQ-021 PRESENT, transfer, manual mode: reload channel sel on the same edge and stay in PRESENT.
  - Sustained throughput is 1 word/cycle.
- REQ-022 PRESENT, transfer, scan mode: set ptr = (out_ch+1) mod N_CH.
  - dwell == 0: reload the next enabled channel on the same edge and stay in PRESENT.
  - dwell > 0: load cnt = dwell and go to DWELL.
- REQ-023 DWELL: cnt decrements each cycle; on the edge where cnt == 1, go to IDLE.
  - After a scan transfer with dwell = D > 0, out_valid is low for D+1 cycles.
- REQ-024 Sel >= N_CH (non-power-of-2 N_CH) SHALL load all-zero data with out_ch = sel.
- REQ-025 A change to mode, sel, ch_mask or dwell while in PRESENT SHALL NOT alter the held word; it takes effect at the next load.
- REQ-026 Wrap-around: the pointer search SHALL proceed N_CH-1 → 0.
  - With a single enabled channel, that channel is reloaded repeatedly.

Reset
- REQ-027 On rst = 1 at an edge, all of the following SHALL hold on the next cycle, overriding any pending handshake:
  - state = IDLE, out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, cnt = 0.
- REQ-028 Reset asserted mid-PRESENT SHALL discard the held word without a transfer.

Configuration
- REQ-029 Macro SCAN_MUX_PARITY_EN defined: the block adds output port out_parity (1 bit).
  - out_parity = even parity (XOR reduction) of the loaded data, registered with out_data, and reset to 0.
- REQ-030 Macro SCAN_MUX_PARITY_EN undefined: the out_parity port and its logic SHALL be absent, with all other behaviour identical.

Structure
- REQ-031 Shared package scan_mux_pkg SHALL hold:
  - the state typedef (IDLE/PRESENT/DWELL);
  - the mode constants MODE_MANUAL = 0 and MODE_SCAN = 1.
- REQ-032 Sub-module rr_next_ch (combinational: ptr + ch_mask → next enabled index + found flag) SHALL implement the REQ-020/REQ-026 search.

Verification (N_CH=4, DATA_W=8)
- REQ-033 Reset: rst high 2 cycles mid-PRESENT → out_valid=0, out_data=0x00, out_ch=0 next cycle.
- REQ-034 Manual back-to-back: i_data={0xDD,0xCC,0xBB,0xAA}, sel=2, out_ready=1 → out_valid from cycle 1 on, out_data=0xCC every cycle.
- REQ-035 Backpressure: sel=1, out_ready=0 for 5 cycles while i_data ch1 changes 0xBB→0x11 → out_data holds 0xBB until out_ready=1.
- REQ-036 Scan with mask: mode=1, ch_mask=4'b1010, dwell=0, out_ready=1 → out_ch sequence 1,3,1,3 with no gaps.
- REQ-037 Dwell and empty mask: dwell=3, ch_mask=4'b1111 → 4 invalid cycles between transfers, out_ch 0,1,2,3,0.
  - Then set ch_mask=0 → out_valid stays 0 after the current word is accepted.
- REQ-038 Parity (macro defined): out_data=0x07 → out_parity=1; out_data=0x03 → out_parity=0.
